// File: rtl/stack_pkg.sv
// Shared types and defaults for the stack operation controller.
package stack_pkg;

  localparam int DEF_WIDTH = 12;
  localparam int DEF_DEPTH = 8;

  // 3-bit opcodes accepted from the instruction sequencer
  typedef enum logic [2:0] {
    OP_PUSH = 3'b000,
    OP_POP  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_NOT  = 3'b110,
    OP_ILL  = 3'b111
  } op_t;

  // Controller sequencing states
  typedef enum logic [2:0] {
    S_IDLE,
    S_POP1,
    S_CAP1,
    S_POP2,
    S_CAP2,
    S_PUSHR,
    S_ERR,
    S_DONE
  } state_t;

endpackage

// File: rtl/stack_alu.sv
// Combinational ALU for stack ops: b is the former top of stack, a the word below it.
module stack_alu
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] y
);

  // Result selection; ADD/SUB wrap naturally at WIDTH bits
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/stack_op_ctrl.sv
// Initiator-side controller driving a stack's push/pop port for one op per start/done handshake.
// Depth is tracked locally so overflow/underflow is rejected before the stack is touched.
module stack_op_ctrl
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int DW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] imm,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [DW-1:0]    depth,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout
);

  state_t           state;
  op_t              op_q;
  op_t              op_in;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;
  logic             accept_ok;

  assign op_in = op_t'(op);

  // Depth precheck for the op being offered in the accept cycle
  always_comb begin
    accept_ok = 1'b0;
    case (op_in)
      OP_PUSH:                     accept_ok = (depth < DW'(DEPTH));
      OP_POP, OP_NOT:              accept_ok = (depth != '0);
      OP_ADD, OP_SUB, OP_AND, OP_OR: accept_ok = (depth >= DW'(2));
      default:                     accept_ok = 1'b0;
    endcase
  end

  // In CAP1 the popped word is still on stk_dout (unary b); in CAP2 b was saved and stk_dout is a
  assign alu_b = (state == S_CAP2) ? b_q : stk_dout;

  stack_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (stk_dout),
    .b  (alu_b),
    .op (op_q),
    .y  (alu_y)
  );

  // Controller FSM with registered handshake/strobe outputs and depth counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= OP_PUSH;
      b_q      <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      result   <= '0;
      depth    <= '0;
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      stk_din  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
      ready    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op_in;
            if (!accept_ok) begin
              state <= S_ERR;
            end else if (op_in == OP_PUSH) begin
              state    <= S_PUSHR;
              stk_push <= 1'b1;
              stk_din  <= imm;
            end else begin
              state   <= S_POP1;
              stk_pop <= 1'b1;
            end
          end else begin
            ready <= 1'b1;
          end
        end
        S_POP1: begin
          depth <= depth - DW'(1);
          state <= S_CAP1;
        end
        S_CAP1: begin
          if (op_q == OP_POP) begin
            result <= stk_dout;
            done   <= 1'b1;
            state  <= S_DONE;
          end else if (op_q == OP_NOT) begin
            stk_din  <= alu_y;
            stk_push <= 1'b1;
            state    <= S_PUSHR;
          end else begin
            b_q     <= stk_dout;
            stk_pop <= 1'b1;
            state   <= S_POP2;
          end
        end
        S_POP2: begin
          depth <= depth - DW'(1);
          state <= S_CAP2;
        end
        S_CAP2: begin
          stk_din  <= alu_y;
          stk_push <= 1'b1;
          state    <= S_PUSHR;
        end
        S_PUSHR: begin
          depth  <= depth + DW'(1);
          result <= stk_din;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_ERR: begin
          done  <= 1'b1;
          err   <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_op_ctrl.sv
// Bench for stack_op_ctrl: behavioural stack block plus a queue-based reference model.
module tb_stack_op_ctrl;

  localparam int WIDTH = 12;
  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [2:0]       op = 3'd0;
  logic [WIDTH-1:0] imm = '0;
  logic             ready, done, err, stk_push, stk_pop;
  logic [WIDTH-1:0] result, stk_din, stk_dout;
  logic [DW-1:0]    depth;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: stack contents and last successful result
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_result = '0;

  // behavioural stack storage block sharing clk/rst
  logic [WIDTH-1:0] sb_mem [DEPTH];
  int               sb_sp;

  always #5 clk = ~clk;

  stack_op_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .imm      (imm),
    .ready    (ready),
    .done     (done),
    .err      (err),
    .result   (result),
    .depth    (depth),
    .stk_push (stk_push),
    .stk_pop  (stk_pop),
    .stk_din  (stk_din),
    .stk_dout (stk_dout)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_sp    <= 0;
      stk_dout <= '0;
    end else if (stk_push) begin
      if (sb_sp < DEPTH) sb_mem[sb_sp] <= stk_din;
      sb_sp <= sb_sp + 1;
    end else if (stk_pop) begin
      if (sb_sp > 0 && sb_sp <= DEPTH) stk_dout <= sb_mem[sb_sp-1];
      sb_sp <= sb_sp - 1;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_result = '0;
  endtask

  // Issue one op, predict it from the model, and compare the observed handshake
  task automatic run_op(input logic [2:0] o, input logic [WIDTH-1:0] im, input bit hold);
    int sz, exp_lat, exp_push, exp_pop, cycles, pushes, pops;
    bit ok, got_done, overlap, stray_err;
    logic [WIDTH-1:0] a, b, r;
    sz = mq.size();
    case (o)
      3'd0:                ok = (sz < DEPTH);
      3'd1, 3'd6:          ok = (sz >= 1);
      3'd2, 3'd3, 3'd4, 3'd5: ok = (sz >= 2);
      default:             ok = 1'b0;
    endcase
    exp_lat = 2; exp_push = 0; exp_pop = 0;
    if (ok) begin
      case (o)
        3'd0: begin
          mq.push_back(im); m_result = im; exp_push = 1;
        end
        3'd1: begin
          b = mq.pop_back(); m_result = b; exp_lat = 3; exp_pop = 1;
        end
        3'd6: begin
          b = mq.pop_back(); r = ~b; mq.push_back(r); m_result = r;
          exp_lat = 4; exp_pop = 1; exp_push = 1;
        end
        default: begin
          b = mq.pop_back(); a = mq.pop_back();
          case (o)
            3'd2:    r = a + b;
            3'd3:    r = a - b;
            3'd4:    r = a & b;
            default: r = a | b;
          endcase
          mq.push_back(r); m_result = r;
          exp_lat = 6; exp_pop = 2; exp_push = 1;
        end
      endcase
    end

    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_before_op%0d: got %b want 1", o, ready);
    end
    start = 1'b1; op = o; imm = im;
    cycles = 0; pushes = 0; pops = 0; got_done = 0; overlap = 0; stray_err = 0;
    while (cycles < 20 && !got_done) begin
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      cycles++;
      if (stk_push) pushes++;
      if (stk_pop) pops++;
      if (stk_push && stk_pop) overlap = 1;
      if (err && !done) stray_err = 1;
      if (cycles == 1 && ready !== 1'b0) stray_err = 1;
      if (done) got_done = 1;
    end
    start = 1'b0;

    n_checks++;
    if (!got_done) begin
      n_fail++; $display("FAIL timeout_op%0d: no done within %0d cycles", o, cycles);
      return;
    end
    n_checks++;
    if (cycles != exp_lat) begin
      n_fail++; $display("FAIL latency_op%0d: got %0d want %0d", o, cycles, exp_lat);
    end
    n_checks++;
    if (err !== !ok) begin
      n_fail++; $display("FAIL err_op%0d: got %b want %b", o, err, !ok);
    end
    n_checks++;
    if (result !== m_result) begin
      n_fail++; $display("FAIL result_op%0d: got %h want %h", o, result, m_result);
    end
    n_checks++;
    if (depth !== DW'(mq.size())) begin
      n_fail++; $display("FAIL depth_op%0d: got %0d want %0d", o, depth, mq.size());
    end
    n_checks++;
    if (pushes != exp_push || pops != exp_pop) begin
      n_fail++;
      $display("FAIL strobes_op%0d: got push=%0d pop=%0d want push=%0d pop=%0d",
               o, pushes, pops, exp_push, exp_pop);
    end
    n_checks++;
    if (overlap || stray_err) begin
      n_fail++; $display("FAIL protocol_op%0d: overlap=%b stray_err_or_ready=%b want 0/0", o, overlap, stray_err);
    end
    // DONE is exactly one cycle, then back in IDLE
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1 || err !== 1'b0) begin
      n_fail++; $display("FAIL done_width_op%0d: got done=%b ready=%b err=%b want 0 1 0", o, done, ready, err);
    end
  endtask

  task automatic test_reset();
    logic [3*WIDTH+DW+4:0] got;
    apply_reset();
    #1;
    got = {ready, done, err, stk_push, stk_pop, depth, result, stk_din, 12'h000};
    n_checks++;
    if (got[3*WIDTH+DW+4:WIDTH] !== {1'b1, 4'b0, {DW{1'b0}}, {WIDTH{1'b0}}, {WIDTH{1'b0}}}) begin
      n_fail++; $display("FAIL reset_values: got %h", got);
    end
  endtask

  task automatic test_sub();
    apply_reset();
    run_op(3'd0, 12'h005, 0);
    run_op(3'd0, 12'h003, 0);
    run_op(3'd3, 12'h000, 0);
    n_checks++;
    if (sb_sp != 1 || sb_mem[0] !== 12'h002) begin
      n_fail++; $display("FAIL sub_stack_top: got sp=%0d top=%h want 1 002", sb_sp, sb_mem[0]);
    end
  endtask

  task automatic test_add_wrap_not();
    apply_reset();
    run_op(3'd0, 12'h001, 0);
    run_op(3'd0, 12'hFFF, 0);
    run_op(3'd2, 12'h000, 0);
    run_op(3'd6, 12'h000, 0);
  endtask

  task automatic test_fill_drain();
    apply_reset();
    for (int i = 1; i <= 8; i++) run_op(3'd0, 12'(i), 0);
    run_op(3'd0, 12'h0AA, 0);
    for (int i = 0; i < 9; i++) run_op(3'd1, 12'h000, 0);
  endtask

  task automatic test_precheck();
    apply_reset();
    run_op(3'd0, 12'h123, 0);
    run_op(3'd2, 12'h000, 0);
    run_op(3'd7, 12'h000, 0);
    run_op(3'd3, 12'h000, 0);
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    run_op(3'd0, 12'h009, 0);
    run_op(3'd0, 12'h004, 0);
    @(negedge clk);
    start = 1'b1; op = 3'd3;
    @(posedge clk); #1; start = 1'b0;   // now in POP1
    @(posedge clk); #1;                 // now in CAP1
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({ready, done, err, stk_push, stk_pop} !== 5'b10000 || depth !== '0 ||
        result !== '0 || stk_din !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_sub: got ready=%b done=%b err=%b push=%b pop=%b depth=%0d result=%h din=%h",
               ready, done, err, stk_push, stk_pop, depth, result, stk_din);
    end
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_result = '0;
    run_op(3'd0, 12'h077, 0);
  endtask

  task automatic test_start_held();
    int extra;
    apply_reset();
    run_op(3'd0, 12'h0AB, 1);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    n_checks++;
    if (extra != 0 || depth !== DW'(1)) begin
      n_fail++; $display("FAIL start_held: got extra_done=%0d depth=%0d want 0 1", extra, depth);
    end
  endtask

  task automatic test_random();
    logic [2:0] o;
    apply_reset();
    for (int i = 0; i < 80; i++) begin
      o = 3'($urandom_range(0, 7));
      if (o == 3'd7 && ($urandom_range(0, 3) != 0)) o = 3'd0;
      run_op(o, 12'($urandom), 0);
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_add_wrap_not();
    test_fill_drain();
    test_precheck();
    test_reset_mid_op();
    test_start_held();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_op_ctrl.md
Name: stack_op_ctrl

Overview:
- Initiator-side controller that drives a stack's push/pop interface on behalf of the datapath.
- Accepts one stack operation per start/done handshake: push immediate, pop, and binary/unary ALU ops that pop operands and push the result.
- Tracks stack depth itself, so overflow and underflow are rejected before the stack is touched.
- Sits between the instruction sequencer and the stack storage block; shares that block's clock and reset.

Parameters:
- WIDTH, 12, data word width (stk_din, stk_dout, imm, result).
- DEPTH, 8, stack capacity in words; depth counter width is $clog2(DEPTH)+1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- op  input  3  opcode (see Behaviour), latched with start.
- imm  input  WIDTH  immediate for PUSH, latched with start.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse at end of every accepted op.
- err  output  1  valid with done; 1 = op rejected, stack untouched.
- result  output  WIDTH  registered; holds its value until the next successful op.
- depth  output  $clog2(DEPTH)+1  current word count.
- stk_push  output  1  push strobe to stack, one cycle.
- stk_pop  output  1  pop strobe to stack, one cycle.
- stk_din  output  WIDTH  push data, valid while stk_push=1.
- stk_dout  input  WIDTH  stack read data; valid in the cycle after a stk_pop cycle.

Behaviour:
- Reset (async, any state):
  - state=IDLE; ready=1; done=0; err=0; result=0; depth=0; stk_push=0; stk_pop=0; stk_din=0.
  - The stack must receive the same rst so depth stays consistent with it.
- Opcodes:
  - 000 PUSH, 001 POP, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 NOT.
  - 111 is illegal: err=1.
- Acceptance:
  - In IDLE, start=1 latches op and imm at the edge.
  - start is ignored while ready=0.
- Precheck (in the accept cycle; any failure goes to ERR):
  - PUSH needs depth<DEPTH.
  - POP and NOT need depth>=1.
  - ADD, SUB, AND, OR need depth>=2.
- States: IDLE, POP1, CAP1, POP2, CAP2, PUSHR, ERR, DONE.
- Sequences:
  - PUSH: IDLE -> PUSHR -> DONE. PUSHR drives stk_push=1, stk_din=imm; depth+1 at the end of PUSHR; result=imm.
  - POP: IDLE -> POP1 -> CAP1 -> DONE. POP1 drives stk_pop=1, depth-1; CAP1 captures b=stk_dout; result=b.
  - NOT: IDLE -> POP1 -> CAP1 -> PUSHR -> DONE. Pushes ~b; result=~b.
  - Binary: IDLE -> POP1 -> CAP1 -> POP2 -> CAP2 -> PUSHR -> DONE.
    - b = top of stack (first pop); a = second pop.
    - SUB computes a-b. ADD/SUB wrap modulo 2^WIDTH; no carry or flags.
    - PUSHR pushes the result; net depth -1.
  - Error: IDLE -> ERR -> DONE. No strobes; depth and result unchanged; err=1 during DONE.
- DONE lasts one cycle: done=1, then back to IDLE.
- err is 0 during DONE for successful ops and 0 outside DONE.
- stk_push and stk_pop are never high together, and never high outside the states listed above.
- Latency from the start edge to done high:
  - PUSH 2 cycles; POP 3; NOT 4; binary 6; error 2.
- A new start can be accepted in the cycle after DONE.
- depth never exceeds DEPTH and never goes below 0.

Decomposition:
- Package stack_pkg holds:
  - op_t enum (3-bit opcodes above);
  - state_t enum;
  - default WIDTH/DEPTH constants.
- One combinational sub-module, stack_alu: inputs a, b, op; output y.
  - Covers ADD, SUB, AND, OR, NOT (NOT uses b only).
- Controller FSM and depth counter stay in stack_op_ctrl.
- The bench instantiates stack_op_ctrl together with the stack block.

Test Plan:
- Reset, then PUSH 5, PUSH 3, SUB -> each done has err=0; SUB result=2 (0x002); depth=1; stack top=2.
- PUSH 0x001, PUSH 0xFFF, ADD -> result=0x000 (wrap); depth=1. Then NOT -> result=0xFFF, depth=1.
- Fill with 8 PUSHes (imm 1..8), then a 9th PUSH -> err=1; no stk_push pulse; depth=8.
  - Then 8 POPs return 8,7,...,1 in that order; a 9th POP -> err=1, depth=0, result stays 1.
- Depth 1, then ADD -> err=1 after 2 cycles; no stk_pop pulse; depth=1. Op 111 -> err=1.
- Assert rst mid-SUB (in CAP1) -> outputs immediately take reset values, depth=0, ready=1.
  - Start held high during a busy op is ignored; exactly one done per accepted op.
